hkspi_responder: RTL and testbench
==================================

HKSPI_RESPONDER -- requirements
Module: hkspi_responder

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 CSB  input  1  SPI chip select from external host, active low, asynchronous to clk.
REQ-004 SCK  input  1  SPI clock from host, mode 0, asynchronous to clk.
REQ-005 SDI  input  1  SPI serial data in, MSB first.
REQ-006 SDO  output  1  SPI serial data out, MSB first.
REQ-007 sdo_enb  output  1  active-low SDO pad enable; 0 only while driving read data.
REQ-008 reg_addr  output  8  register address.
REQ-009 reg_wdata  output  8  register write data.
REQ-010 reg_wr  output  1  one-cycle write strobe.
REQ-011 reg_rd  output  1  one-cycle read strobe.
REQ-012 reg_rdata  input  8  read data; combinational from reg_addr and valid in the reg_rd cycle.
REQ-013 pass_thru  output  1  high while the pass-thru session is active.
REQ-014 pt_sdo  input  1  flash data forwarded to SDO during pass-thru.

Function
REQ-015 CSB, SCK and SDI SHALL pass through 2-flop synchronizers; SCK edges are detected on synchronized values (3-cycle input latency); SCK high and low times are each >= 4 clk periods.
REQ-016 SDI SHALL be sampled on each SCK rising edge; SDO SHALL change only on SCK falling edges, except for the first bit of a read byte (REQ-022).
REQ-017 State machine: IDLE, COMMAND, ADDRESS, DATA, PASSTHRU. Synchronized CSB falling edge: IDLE->COMMAND, bit counter cleared.
REQ-018 COMMAND, after 8 bits: 0x80 = write stream, 0x40 = read stream, 0xC0 = read/write stream, all -> ADDRESS; 0xC4 -> PASSTHRU; any other value -> IDLE-equivalent ignore state until CSB rises, with no strobes.
REQ-019 ADDRESS, after 8 bits: load reg_addr, go to DATA; in read modes, assert reg_rd one cycle later.
REQ-020 DATA write: after each 8th bit, reg_wdata = byte, reg_wr pulses for exactly 1 cycle, and reg_addr increments on the following cycle.
REQ-021 DATA read: on each reg_rd cycle, capture reg_rdata into the output shifter; after each 8 bits, increment reg_addr and pulse reg_rd for the next byte.
REQ-022 DATA read: the first bit of each captured byte SHALL be on SDO within 2 clk of the capture, before the next SCK rising edge.
REQ-023 Read/write mode: the write of byte N and the read of address N+1 SHALL both occur.
REQ-024 reg_addr SHALL wrap 0xFF->0x00 with no error indication.
REQ-025 PASSTHRU: pass_thru = 1, SDO = pt_sdo (combinational), sdo_enb = 0; the block performs no register strobes; it exits only on CSB rise.
REQ-026 Synchronized CSB rising edge in any state: -> IDLE in 1 cycle; any partial byte is discarded (no reg_wr); pass_thru = 0; sdo_enb = 1.
REQ-027 A CSB rise coincident with the 8th-bit SCK rising edge SHALL still complete that byte's strobe, then go to IDLE.
REQ-028 reg_wr and reg_rd SHALL never be high in the same cycle; in read/write mode reg_wr precedes reg_rd by 1 cycle.

Reset
REQ-029 Synchronous reset SHALL force: state IDLE, SDO = 0, sdo_enb = 1, reg_addr = 0x00, reg_wdata = 0x00, reg_wr = 0, reg_rd = 0, pass_thru = 0, counters 0, synchronizers to CSB = 1, SCK = 0, SDI = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it; with CSB still low after reset, no bytes are decoded until a fresh CSB falling edge.

Verification
REQ-031 Read: CSB low, send 0x40, 0x03, read 1 byte, with reg_rdata model returning 0x03 at addr 3 -> SDO byte 0x03, one reg_rd at reg_addr = 0x03, no reg_wr.
REQ-032 Write stream: send 0x80, 0xFE, then 0x11, 0x22, 0x33 -> reg_wr at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 (wrap checked).
REQ-033 Pass-thru: send 0xC4, then 0x03 0x10 0x00 0x00 while toggling pt_sdo -> pass_thru = 1 from the 8th command bit; SDO tracks pt_sdo; no strobes; CSB high -> pass_thru = 0 within 4 clk.
REQ-034 Abort: send 0x80, 0x05, then 5 bits, then CSB high -> no reg_wr; the next transaction 0x40, 0x05 reads correctly.
REQ-035 Unknown command 0x00 followed by 3 bytes -> no strobes; sdo_enb stays 1.
REQ-036 Reset pulse during the DATA phase of a read stream -> all outputs reach their reset values on the next clk; the following transaction is correct.

Source files
------------

// File: rtl/hkspi_responder.sv
// SPI housekeeping responder: oversamples the host SPI pins in the clk domain and turns
// command/address/data bytes into register read/write strobes, plus a flash pass-thru mode.
module hkspi_responder (
   input  logic       clk,
   input  logic       reset,
   input  logic       CSB,
   input  logic       SCK,
   input  logic       SDI,
   output logic       SDO,
   output logic       sdo_enb,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       pass_thru,
   input  logic       pt_sdo
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_COMMAND, ST_ADDRESS, ST_DATA, ST_PASSTHRU, ST_IGNORE
   } state_t;

   state_t     state_q, state_d;
   logic       csb_s1_q, csb_s1_d, csb_s2_q, csb_s2_d, csb_prev_q, csb_prev_d;
   logic [1:0] csb_vld_q, csb_vld_d;
   logic       csb_arm_q, csb_arm_d;
   logic       sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_s3_q, sck_s3_d;
   logic       sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] sdo_shift_q, sdo_shift_d;
   logic       wr_mode_q, wr_mode_d, rd_mode_q, rd_mode_d;
   logic       inc_pend_q, inc_pend_d;
   logic [7:0] reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
   logic       reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
   logic       sdo_q, sdo_d, sdo_enb_q, sdo_enb_d, pass_thru_q, pass_thru_d;

   logic       csb_fall, csb_rise, sck_rise, sck_fall, byte_done;
   logic [7:0] rx_byte;

   always_comb begin
      csb_s1_d   = CSB;
      csb_s2_d   = csb_s1_q;
      csb_prev_d = csb_s2_q;
      sck_s1_d   = SCK;
      sck_s2_d   = sck_s1_q;
      sck_s3_d   = sck_s2_q;
      sdi_s1_d   = SDI;
      sdi_s2_d   = sdi_s1_q;
      // A falling CSB only counts once a real high has been seen since reset, so a
      // host still holding CSB low across reset cannot start a transaction.
      csb_vld_d  = {csb_vld_q[0], 1'b1};
      csb_arm_d  = csb_arm_q | (csb_vld_q[1] & csb_s2_q);

      csb_fall  = csb_arm_q & csb_prev_q & ~csb_s2_q;
      csb_rise  = ~csb_prev_q & csb_s2_q;
      sck_rise  = sck_s2_q & ~sck_s3_q;
      sck_fall  = ~sck_s2_q & sck_s3_q;
      rx_byte   = {shift_q[6:0], sdi_s2_q};
      byte_done = sck_rise & (bit_cnt_q == 3'd7);

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sdo_shift_d = sdo_shift_q;
      wr_mode_d   = wr_mode_q;
      rd_mode_d   = rd_mode_q;
      inc_pend_d  = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      sdo_d       = sdo_q;
      sdo_enb_d   = sdo_enb_q;
      pass_thru_d = pass_thru_q;

      // Address advances one cycle after a data byte so a write lands at the old address.
      if (inc_pend_q) begin
         reg_addr_d = reg_addr_q + 8'd1;
         reg_rd_d   = rd_mode_q & (state_q == ST_DATA) & ~csb_rise;
      end

      if (reg_rd_q) begin
         sdo_shift_d = reg_rdata;
         sdo_d       = reg_rdata[7];
         sdo_enb_d   = 1'b0;
      end else if (sck_fall && state_q == ST_DATA && rd_mode_q && bit_cnt_q != 3'd0) begin
         sdo_shift_d = {sdo_shift_q[6:0], 1'b0};
         sdo_d       = sdo_shift_q[6];
      end

      if (sck_rise && (state_q == ST_COMMAND || state_q == ST_ADDRESS || state_q == ST_DATA)) begin
         shift_d   = rx_byte;
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
         ST_IDLE: if (csb_fall) begin
            state_d   = ST_COMMAND;
            bit_cnt_d = 3'd0;
            wr_mode_d = 1'b0;
            rd_mode_d = 1'b0;
         end
         ST_COMMAND: if (byte_done) begin
            if (rx_byte == 8'h80 || rx_byte == 8'h40 || rx_byte == 8'hC0) begin
               wr_mode_d = rx_byte[7];
               rd_mode_d = rx_byte[6];
               state_d   = ST_ADDRESS;
            end else if (rx_byte == 8'hC4) begin
               state_d     = ST_PASSTHRU;
               pass_thru_d = 1'b1;
               sdo_enb_d   = 1'b0;
            end else begin
               state_d = ST_IGNORE;
            end
         end
         ST_ADDRESS: if (byte_done) begin
            reg_addr_d = rx_byte;
            reg_rd_d   = rd_mode_q & ~csb_rise;
            state_d    = ST_DATA;
         end
         ST_DATA: if (byte_done) begin
            if (wr_mode_q) begin
               reg_wr_d    = 1'b1;
               reg_wdata_d = rx_byte;
            end
            inc_pend_d = 1'b1;
         end
         default: ;
      endcase

      // Ending the session wins over everything except a byte strobe already decided above.
      if (csb_rise && state_q != ST_IDLE) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = 3'd0;
         sdo_d       = 1'b0;
         sdo_enb_d   = 1'b1;
         pass_thru_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         csb_s1_q    <= 1'b1;
         csb_s2_q    <= 1'b1;
         csb_prev_q  <= 1'b1;
         csb_vld_q   <= 2'b00;
         csb_arm_q   <= 1'b0;
         sck_s1_q    <= 1'b0;
         sck_s2_q    <= 1'b0;
         sck_s3_q    <= 1'b0;
         sdi_s1_q    <= 1'b0;
         sdi_s2_q    <= 1'b0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         sdo_shift_q <= 8'h00;
         wr_mode_q   <= 1'b0;
         rd_mode_q   <= 1'b0;
         inc_pend_q  <= 1'b0;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         sdo_q       <= 1'b0;
         sdo_enb_q   <= 1'b1;
         pass_thru_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         csb_s1_q    <= csb_s1_d;
         csb_s2_q    <= csb_s2_d;
         csb_prev_q  <= csb_prev_d;
         csb_vld_q   <= csb_vld_d;
         csb_arm_q   <= csb_arm_d;
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_s3_q    <= sck_s3_d;
         sdi_s1_q    <= sdi_s1_d;
         sdi_s2_q    <= sdi_s2_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sdo_shift_q <= sdo_shift_d;
         wr_mode_q   <= wr_mode_d;
         rd_mode_q   <= rd_mode_d;
         inc_pend_q  <= inc_pend_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         sdo_q       <= sdo_d;
         sdo_enb_q   <= sdo_enb_d;
         pass_thru_q <= pass_thru_d;
      end
   end

   assign SDO       = pass_thru_q ? pt_sdo : sdo_q;
   assign sdo_enb   = sdo_enb_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign pass_thru = pass_thru_q;

endmodule

// File: tb/tb_hkspi_responder.sv
// Bench for hkspi_responder: SPI host tasks, a register-file model and a transaction-level
// reference that predicts strobes and read-back bytes from the command rules.
module tb_hkspi_responder;
   localparam int HALF = 6;

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  addr;
      int          n;
      logic [31:0] data;
      int          exp_wr;
      int          exp_rd;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b1, CSB = 1'b1, SCK = 1'b0, SDI = 1'b0, pt_sdo = 1'b0;
   logic       SDO, sdo_enb, reg_wr, reg_rd, pass_thru;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] mem [256];
   int         checks = 0, failures = 0, cyc = 0, both_cnt = 0, enb_low_cnt = 0;
   logic [15:0] wq[$];
   logic [7:0]  rq[$];
   int          wcyc[$], rcyc[$];

   always #5 clk = ~clk;
   assign reg_rdata = mem[reg_addr];

   hkspi_responder dut (
      .clk(clk), .reset(reset), .CSB(CSB), .SCK(SCK), .SDI(SDI), .SDO(SDO),
      .sdo_enb(sdo_enb), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
      .reg_rd(reg_rd), .reg_rdata(reg_rdata), .pass_thru(pass_thru), .pt_sdo(pt_sdo)
   );

   // Register file: refilled with random contents while reset is held, address 3 holds 0x03.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
         mem[3] <= 8'h03;
      end else if (reg_wr) begin
         mem[reg_addr] <= reg_wdata;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (reg_wr) begin wq.push_back({reg_addr, reg_wdata}); wcyc.push_back(cyc); end
         if (reg_rd) begin rq.push_back(reg_addr); rcyc.push_back(cyc); end
         if (reg_wr && reg_rd) both_cnt++;
         if (!sdo_enb) enb_low_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nb, input bit csb_last,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nb; i++) begin
         SDI = tx[7-i];
         repeat (HALF) @(negedge clk);
         rx = {rx[6:0], SDO};
         SCK = 1'b1;
         if (csb_last && i == nb - 1) CSB = 1'b1;
         repeat (HALF) @(negedge clk);
         SCK = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sdo"}, SDO, 0);
      chk({tag, "_sdo_enb"}, sdo_enb, 1);
      chk({tag, "_reg_addr"}, reg_addr, 0);
      chk({tag, "_reg_wdata"}, reg_wdata, 0);
      chk({tag, "_reg_wr"}, reg_wr, 0);
      chk({tag, "_reg_rd"}, reg_rd, 0);
      chk({tag, "_pass_thru"}, pass_thru, 0);
   endtask

   // Reference: reads run start..start+n (one prefetch past the last byte), writes start..start+n-1,
   // and every read byte is the memory content from before the transaction.
   task automatic run_txn(input vec_t v);
      logic [7:0] rxb, d;
      logic [7:0] snap [5];
      int w0, r0, e0;
      bit wm, rm;
      wm = (v.cmd == 8'h80) || (v.cmd == 8'hC0);
      rm = (v.cmd == 8'h40) || (v.cmd == 8'hC0);
      for (int i = 0; i <= v.n; i++) snap[i] = mem[8'(v.addr + i)];
      w0 = wq.size(); r0 = rq.size(); e0 = enb_low_cnt;
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(v.cmd, 8, 0, rxb);
      spi_bits(v.addr, 8, 0, rxb);
      for (int i = 0; i < v.n; i++) begin
         d = v.data[31-8*i -: 8];
         spi_bits(d, 8, 0, rxb);
         if (rm) chk($sformatf("rx_byte%0d_cmd%0h", i, v.cmd), rxb, snap[i]);
      end
      repeat (HALF) @(negedge clk);
      CSB = 1'b1;
      repeat (8) @(negedge clk);
      chk($sformatf("wr_count_cmd%0h", v.cmd), wq.size() - w0, v.exp_wr);
      chk($sformatf("rd_count_cmd%0h", v.cmd), rq.size() - r0, v.exp_rd);
      if (wm) for (int i = 0; i < v.n; i++)
         if (w0 + i < wq.size())
            chk($sformatf("wr%0d_addr_data", i), wq[w0+i], {8'(v.addr + i), v.data[31-8*i -: 8]});
      if (rm) for (int i = 0; i <= v.n; i++)
         if (r0 + i < rq.size()) chk($sformatf("rd%0d_addr", i), rq[r0+i], 8'(v.addr + i));
      if (wm && rm) for (int i = 0; i < v.n; i++)
         if (w0 + i < wq.size() && r0 + i + 1 < rq.size())
            chk($sformatf("rw%0d_wr_then_rd", i), rcyc[r0+i+1] - wcyc[w0+i], 1);
      if (!rm) chk($sformatf("sdo_enb_high_cmd%0h", v.cmd), enb_low_cnt - e0, 0);
   endtask

   initial begin
      vec_t tbl [7];
      vec_t v;
      logic [7:0] rxb;
      logic [31:0] pt_bytes;
      int w0, r0, e0;

      tbl[0] = '{8'h80, 8'hFE, 3, 32'h11223300, 3, 0};
      tbl[1] = '{8'h40, 8'h03, 1, 32'h00000000, 0, 2};
      tbl[2] = '{8'hC0, 8'h20, 2, 32'hA55A0000, 2, 3};
      tbl[3] = '{8'hC0, 8'hFF, 2, 32'h01020000, 2, 3};
      tbl[4] = '{8'h00, 8'h00, 2, 32'hFFFF0000, 0, 0};
      tbl[5] = '{8'h40, 8'hFE, 3, 32'h00000000, 0, 4};
      tbl[6] = '{8'h80, 8'h7F, 0, 32'h00000000, 0, 0};

      repeat (4) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single-byte read ending with CSB rising on the last SCK edge: exactly one read strobe.
      w0 = wq.size(); r0 = rq.size();
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h40, 8, 0, rxb);
      spi_bits(8'h03, 8, 0, rxb);
      spi_bits(8'h00, 8, 1, rxb);
      repeat (8) @(negedge clk);
      chk("read1_sdo_byte", rxb, 8'h03);
      chk("read1_rd_count", rq.size() - r0, 1);
      if (rq.size() > r0) chk("read1_rd_addr", rq[r0], 8'h03);
      chk("read1_wr_count", wq.size() - w0, 0);

      // Write whose final bit coincides with CSB rising still commits.
      w0 = wq.size();
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h80, 8, 0, rxb);
      spi_bits(8'h10, 8, 0, rxb);
      spi_bits(8'hA5, 8, 1, rxb);
      repeat (8) @(negedge clk);
      chk("csb_edge_wr_count", wq.size() - w0, 1);
      if (wq.size() > w0) chk("csb_edge_wr", wq[w0], 16'h10A5);
      chk("csb_edge_state_idle_enb", sdo_enb, 1);

      for (int t = 0; t < 7; t++) run_txn(tbl[t]);

      // Pass-thru: SDO follows pt_sdo, no strobes, released within 4 clk of CSB rising.
      w0 = wq.size(); r0 = rq.size();
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      chk("pt_before", pass_thru, 0);
      spi_bits(8'hC4, 8, 0, rxb);
      chk("pt_active", pass_thru, 1);
      chk("pt_sdo_enb", sdo_enb, 0);
      pt_bytes = 32'h03100000;
      for (int b = 0; b < 32; b++) begin
         SDI = pt_bytes[31-b];
         pt_sdo = 1'($urandom);
         repeat (HALF) @(negedge clk);
         chk("pt_sdo_track", SDO, pt_sdo);
         SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         SCK = 1'b0;
      end
      chk("pt_no_wr", wq.size() - w0, 0);
      chk("pt_no_rd", rq.size() - r0, 0);
      CSB = 1'b1;
      repeat (4) @(negedge clk);
      chk("pt_exit", pass_thru, 0);
      chk("pt_exit_enb", sdo_enb, 1);
      repeat (4) @(negedge clk);

      // Abort after 5 data bits: nothing written, then a clean read.
      w0 = wq.size(); r0 = rq.size();
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h80, 8, 0, rxb);
      spi_bits(8'h05, 8, 0, rxb);
      spi_bits(8'hFF, 5, 0, rxb);
      repeat (HALF) @(negedge clk);
      CSB = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_no_wr", wq.size() - w0, 0);
      chk("abort_no_rd", rq.size() - r0, 0);
      v = '{8'h40, 8'h05, 1, 32'h0, 0, 2};
      run_txn(v);

      // Reset in the data phase of a read stream, CSB held low afterwards.
      CSB = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h40, 8, 0, rxb);
      spi_bits(8'h40, 8, 0, rxb);
      spi_bits(8'h00, 8, 0, rxb);
      spi_bits(8'h00, 3, 0, rxb);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midreset");
      reset = 1'b0;
      w0 = wq.size(); r0 = rq.size(); e0 = enb_low_cnt;
      spi_bits(8'hC0, 8, 0, rxb);
      spi_bits(8'h12, 8, 0, rxb);
      spi_bits(8'h34, 8, 0, rxb);
      chk("postreset_no_wr", wq.size() - w0, 0);
      chk("postreset_no_rd", rq.size() - r0, 0);
      chk("postreset_enb_high", enb_low_cnt - e0, 0);
      CSB = 1'b1;
      repeat (8) @(negedge clk);
      v = '{8'h40, 8'h41, 1, 32'h0, 0, 2};
      run_txn(v);

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 3))
            0: v.cmd = 8'h80;
            1: v.cmd = 8'h40;
            2: v.cmd = 8'hC0;
            default: begin
               v.cmd = 8'($urandom);
               while (v.cmd == 8'h80 || v.cmd == 8'h40 || v.cmd == 8'hC0 || v.cmd == 8'hC4)
                  v.cmd = 8'($urandom);
            end
         endcase
         v.addr = 8'($urandom);
         v.n    = int'($urandom_range(0, 4));
         v.data = $urandom;
         v.exp_wr = (v.cmd == 8'h80 || v.cmd == 8'hC0) ? v.n : 0;
         v.exp_rd = (v.cmd == 8'h40 || v.cmd == 8'hC0) ? v.n + 1 : 0;
         run_txn(v);
      end

      chk("no_wr_rd_overlap", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
